// File: rtl/uart_cmd_exec_pkg.sv
// Shared definitions for the UART command executor: FSM states, decoder
// opcodes, keyword and control-character constants, and the log2 helper.
package uart_cmd_exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_COPY,
    ST_TERM,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ECHO,
    OP_REV,
    OP_UP,
    OP_EMPTY,
    OP_BAD
  } op_t;

  // Keywords as packed strings, first character in the most significant byte.
  localparam logic [39:0] KW_ECHO_SP = "echo ";
  localparam logic [31:0] KW_ECHO    = "echo";
  localparam logic [31:0] KW_REV_SP  = "rev ";
  localparam logic [23:0] KW_REV     = "rev";
  localparam logic [23:0] KW_UP_SP   = "up ";
  localparam logic [15:0] KW_UP      = "up";

  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_QMARK   = 8'h3F;
  localparam logic [7:0] CH_LOWER_A = 8'h61;
  localparam logic [7:0] CH_LOWER_Z = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  localparam logic [15:0] BANNER_TEXT = "ok";

  // Floor of log2; log2(LEN-1)+1 gives the bits needed to address LEN bytes.
  function automatic int log2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_exec_decode.sv
// Combinational keyword classifier. Bytes beyond K in the keyword register
// are zero, so an exact short keyword compares cleanly against the constants.
module cmd_keyword_decode
  import uart_cmd_exec_pkg::*;
(
  input  logic [39:0] kw_str,
  input  logic [2:0]  k,
  output op_t         op,
  output logic [2:0]  arg_off
);

  // Longest keyword first so "rev " is not mistaken for the bare "rev".
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    op      = OP_BAD;
    arg_off = 3'd0;
    if (k == 3'd0) begin
      op = OP_EMPTY;
    end else if (k == 3'd5 && kw_str == KW_ECHO_SP) begin
      op      = OP_ECHO;
      arg_off = 3'd5;
    end else if (k == 3'd4 && kw_str[39:8] == KW_ECHO) begin
      op = OP_EMPTY;
    end else if (k >= 3'd4 && kw_str[39:8] == KW_REV_SP) begin
      op      = OP_REV;
      arg_off = 3'd4;
    end else if (k == 3'd3 && kw_str[39:16] == KW_REV) begin
      op = OP_EMPTY;
    end else if (k >= 3'd3 && kw_str[39:16] == KW_UP_SP) begin
      op      = OP_UP;
      arg_off = 3'd3;
    end else if (k == 3'd2 && kw_str[39:24] == KW_UP) begin
      op = OP_EMPTY;
    end
  end

endmodule

// File: rtl/uart_cmd_exec.sv
// Command executor: fetches the keyword from the RX region, decodes it, and
// builds the response (argument copy, reverse or upcase, then CR/LF) in the
// TX region before handing it back with msg_valid/msg_len.
module uart_cmd_exec
  import uart_cmd_exec_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN        = 256,
  parameter int RXSTR_BASE = 0,
  parameter int TXSTR_BASE = 128,
  parameter int BANNER     = 0,
  parameter int AW         = log2(LEN - 1) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [AW-1:0]    cmd_len,
  output logic             msg_valid,
  output logic [AW-1:0]    msg_len,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_we,
  output logic             busy,
  output logic             overrun
);

  localparam logic [AW-1:0] RX_BASE     = AW'(RXSTR_BASE);
  localparam logic [AW-1:0] TX_BASE     = AW'(TXSTR_BASE);
  localparam logic [AW-1:0] LEN_CAP     = AW'(TXSTR_BASE - RXSTR_BASE);
  // Largest response body that still leaves room for CR/LF below LEN.
  localparam logic [AW-1:0] N_MAX       = AW'(LEN - TXSTR_BASE - 2);
  localparam state_t        RESET_STATE = (BANNER != 0) ? ST_COPY : ST_IDLE;

  state_t          state_q, state_d;
  logic [AW-1:0]   len_q;
  logic [2:0]      k_q;
  logic [4:0][7:0] kw_q;
  logic [AW-1:0]   cnt_q;
  logic            phase_q;
  logic [AW-1:0]   n_q;
  op_t             op_q;
  logic [2:0]      off_q;
  logic            banner_q;
  logic [AW-1:0]   msg_len_q;
  logic            cmd_valid_q;

  logic            arrival;
  logic [AW-1:0]   len_clamped;
  logic [2:0]      k_init;
  logic [39:0]     kw_str;
  op_t             op_dec;
  logic [2:0]      off_dec;
  logic [AW-1:0]   arg_len;
  logic [AW-1:0]   n_dec;
  logic [AW-1:0]   src_addr;
  logic [7:0]      rbyte;
  logic [7:0]      up_byte;
  logic [7:0]      copy_byte;
  logic [7:0]      wbyte;
  logic            unused_rdata;

  // Only the low byte of the RAM word carries data; the rest is folded into a sink.
  assign rbyte        = mem_rdata[7:0];
  assign unused_rdata = ^mem_rdata;

  // A held cmd_valid is one command: only its rising edge counts.
  assign arrival     = cmd_valid & ~cmd_valid_q;
  assign len_clamped = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;
  assign k_init      = (len_clamped >= AW'(5)) ? 3'd5 : len_clamped[2:0];
  assign kw_str      = {kw_q[0], kw_q[1], kw_q[2], kw_q[3], kw_q[4]};

  cmd_keyword_decode u_decode (
    .kw_str  (kw_str),
    .k       (k_q),
    .op      (op_dec),
    .arg_off (off_dec)
  );

  // Response body length from the decoded opcode, truncated to fit the TX region.
  always_comb begin
    arg_len = '0;
    case (op_dec)
      OP_ECHO, OP_REV, OP_UP: begin
        if (len_q > AW'(off_dec)) arg_len = len_q - AW'(off_dec);
      end
      OP_BAD:  arg_len = AW'(1);
      default: arg_len = '0;
    endcase
    n_dec = (arg_len > N_MAX) ? N_MAX : arg_len;
  end

  // Reverse walks from the last command byte down; other modes walk forward.
  assign src_addr = (op_q == OP_REV) ? (RX_BASE + len_q - AW'(1) - cnt_q)
                                     : (RX_BASE + AW'(off_q) + cnt_q);
  assign up_byte  = (rbyte >= CH_LOWER_A && rbyte <= CH_LOWER_Z) ? (rbyte - CASE_DELTA) : rbyte;

  // Select the byte written in a COPY write cycle.
  always_comb begin
    copy_byte = rbyte;
    if (banner_q) begin
      copy_byte = (cnt_q == '0) ? BANNER_TEXT[15:8] : BANNER_TEXT[7:0];
    end else begin
      case (op_q)
        OP_BAD:  copy_byte = CH_QMARK;
        OP_UP:   copy_byte = up_byte;
        default: copy_byte = rbyte;
      endcase
    end
  end

  // Next-state logic and RAM port drive.
  always_comb begin
    state_d  = state_q;
    mem_addr = '0;
    mem_we   = 1'b0;
    wbyte    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (arrival) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (cnt_q < AW'(k_q)) mem_addr = RX_BASE + cnt_q;
        if (cnt_q == AW'(k_q)) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (n_dec == '0) ? ST_TERM : ST_COPY;
      end
      ST_COPY: begin
        if (!phase_q) begin
          mem_addr = src_addr;
        end else begin
          mem_addr = TX_BASE + cnt_q;
          mem_we   = 1'b1;
          wbyte    = copy_byte;
          if (cnt_q + AW'(1) == n_q) state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        mem_addr = TX_BASE + n_q + AW'(phase_q);
        mem_we   = 1'b1;
        wbyte    = phase_q ? CH_LF : CH_CR;
        if (phase_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      len_q       <= '0;
      k_q         <= 3'd0;
      kw_q        <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      n_q         <= (BANNER != 0) ? AW'(2) : '0;
      op_q        <= OP_EMPTY;
      off_q       <= 3'd0;
      banner_q    <= (BANNER != 0);
      msg_len_q   <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid;
      case (state_q)
        ST_IDLE: begin
          if (arrival) begin
            len_q    <= len_clamped;
            k_q      <= k_init;
            kw_q     <= '0;
            cnt_q    <= '0;
            banner_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          // Read data lags the address by one cycle, so slot cnt-1 lands now.
          if (cnt_q != '0) kw_q[3'(cnt_q - AW'(1))] <= rbyte;
          cnt_q <= cnt_q + AW'(1);
        end
        ST_DECODE: begin
          n_q     <= n_dec;
          op_q    <= op_dec;
          off_q   <= off_dec;
          cnt_q   <= '0;
          phase_q <= 1'b0;
        end
        ST_COPY: begin
          phase_q <= ~phase_q;
          if (phase_q) cnt_q <= cnt_q + AW'(1);
        end
        ST_TERM: begin
          phase_q <= ~phase_q;
          if (phase_q) msg_len_q <= n_q + AW'(2);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign msg_valid = (state_q == ST_DONE);
  assign overrun   = arrival & busy;
  assign msg_len   = msg_len_q;
  assign mem_wdata = WIDTH'(wbyte);

endmodule

// File: tb/tb_uart_cmd_exec.sv
// Self-checking bench for uart_cmd_exec: a table of command lines with
// hand-computed responses and timing, plus sequences for overrun, held
// cmd_valid, reset mid-copy, long-argument clamping and the banner.
module tb_uart_cmd_exec;

  localparam int TX = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = 8'd0;
  logic       msg_valid;
  logic [7:0] msg_len;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic       busy;
  logic       overrun;

  logic       cmd_valid_b = 1'b0;
  logic [7:0] cmd_len_b = 8'd0;
  logic       msg_valid_b;
  logic [7:0] msg_len_b;
  logic [7:0] mem_addr_b;
  logic [7:0] mem_wdata_b;
  logic [7:0] mem_rdata_b;
  logic       mem_we_b;
  logic       busy_b;
  logic       overrun_b;

  logic [7:0] cmd_mem [0:127];
  logic [7:0] tx_mem [0:255];
  logic [7:0] tx_mem_b [0:255];

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int mv_cnt = 0;
  int bad_wr = 0;
  int max_wr = 0;

  always #5 clk = ~clk;

  uart_cmd_exec #(.WIDTH(8), .LEN(256), .RXSTR_BASE(0), .TXSTR_BASE(TX), .BANNER(0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
    .msg_valid(msg_valid), .msg_len(msg_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .busy(busy), .overrun(overrun)
  );

  uart_cmd_exec #(.WIDTH(8), .LEN(256), .RXSTR_BASE(0), .TXSTR_BASE(TX), .BANNER(1)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_len(cmd_len_b),
    .msg_valid(msg_valid_b), .msg_len(msg_len_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_we(mem_we_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  // RAM model: the RX half comes from the bench-loaded command buffer.
  always @(posedge clk) begin
    if (mem_we) tx_mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < 8'd128) ? cmd_mem[mem_addr[6:0]] : tx_mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we_b) tx_mem_b[mem_addr_b] <= mem_wdata_b;
    mem_rdata_b <= tx_mem_b[mem_addr_b];
  end

  // Event monitor, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (overrun === 1'b1) ovr_cnt++;
    if (msg_valid === 1'b1) mv_cnt++;
    if (mem_we === 1'b1) begin
      if (mem_addr < 8'd128) bad_wr++;
      if (int'(mem_addr) > max_wr) max_wr = int'(mem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic load_cmd(input string s);
    for (int i = 0; i < s.len(); i++) cmd_mem[i] = s[i];
  endtask

  // Launch a command and wait for msg_valid; cycle 0 is the sampling cycle.
  task automatic wait_msg(input string name, input int len, input int cyc_exp, input int mlen);
    int  cyc;
    bit  seen;
    cmd_len = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      if (msg_valid === 1'b1) seen = 1'b1;
    end
    check({name, "_msg_valid_seen"}, 32'(seen), 1);
    check({name, "_cycle"}, cyc, cyc_exp);
    check({name, "_msg_len"}, 32'(msg_len), mlen);
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic run_cmd(input string name, input string cmd, input string resp,
                         input int mlen, input int cyc_exp);
    load_cmd(cmd);
    wait_msg(name, cmd.len(), cyc_exp, mlen);
    for (int i = 0; i < resp.len(); i++)
      check($sformatf("%s_byte%0d", name, i), 32'(tx_mem[TX + i]), 32'(resp[i]));
    check({name, "_cr"}, 32'(tx_mem[TX + resp.len()]), 32'h0D);
    check({name, "_lf"}, 32'(tx_mem[TX + resp.len() + 1]), 32'h0A);
  endtask

  // Fixed-length run: cmd_valid high for cycles < hold, plus a pulse at
  // pulse_at; rst pulsed at rst_at; outputs captured the cycle after reset.
  task automatic run_seq(input int len, input int pulse_at, input int hold, input int rst_at,
                         input int total, output logic we_after, output logic busy_after,
                         output logic mv_after);
    we_after   = 1'bx;
    busy_after = 1'bx;
    mv_after   = 1'bx;
    cmd_len = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      cmd_valid = (c < hold) || (c == pulse_at);
      rst       = (c == rst_at);
      if (c == rst_at + 1) begin
        we_after   = mem_we;
        busy_after = busy;
        mv_after   = msg_valid;
      end
    end
    cmd_valid = 1'b0;
    rst       = 1'b0;
    #3;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(8'h61 + (i * 7) % 26);
  endfunction

  typedef struct {
    string cmd;
    string resp;
    int    mlen;
    int    cyc;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    int   ovr0, mv0, bcyc;
    bit   bseen;
    logic we_a, busy_a, mv_a;

    vecs[0]  = '{"echo hi", "hi",   4, 14};
    vecs[1]  = '{"rev abc", "cba",  5, 16};
    vecs[2]  = '{"up aZ9",  "AZ9",  5, 16};
    vecs[3]  = '{"",        "",     2, 5};
    vecs[4]  = '{"xyz",     "?",    3, 10};
    vecs[5]  = '{"echo",    "",     2, 9};
    vecs[6]  = '{"rev ",    "",     2, 9};
    vecs[7]  = '{"up",      "",     2, 7};
    vecs[8]  = '{"Echo x",  "?",    3, 12};
    vecs[9]  = '{"rev z",   "z",    3, 12};
    vecs[10] = '{"up az{@", "AZ{@", 6, 18};
    vecs[11] = '{"echox",   "?",    3, 12};
    vecs[12] = '{"echo ",   "",     2, 10};
    vecs[13] = '{"up ",     "",     2, 8};

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    check("rst_msg_valid", 32'(msg_valid), 0);
    check("rst_msg_len",   32'(msg_len), 0);
    check("rst_mem_addr",  32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_mem_we",    32'(mem_we), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_overrun",   32'(overrun), 0);
    rst = 1'b0;

    // Banner instance emits "ok\r\n" without any command.
    bcyc  = 0;
    bseen = 1'b0;
    while (!bseen && bcyc < 50) begin
      @(negedge clk);
      bcyc++;
      if (msg_valid_b === 1'b1) bseen = 1'b1;
    end
    check("banner_seen", 32'(bseen), 1);
    check("banner_msg_len", 32'(msg_len_b), 4);
    check("banner_b0", 32'(tx_mem_b[TX]),     32'h6F);
    check("banner_b1", 32'(tx_mem_b[TX + 1]), 32'h6B);
    check("banner_b2", 32'(tx_mem_b[TX + 2]), 32'h0D);
    check("banner_b3", 32'(tx_mem_b[TX + 3]), 32'h0A);
    check("idle_busy_no_cmd", 32'(busy), 0);

    for (int v = 0; v < NV; v++)
      run_cmd($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].resp, vecs[v].mlen, vecs[v].cyc);

    // Long "echo " line: length clamps to 128, so 123 argument bytes.
    load_cmd("echo ");
    for (int i = 5; i < 128; i++) cmd_mem[i] = pat(i);
    wait_msg("long", 205, 5 + 2 * 123 + 5, 125);
    for (int i = 0; i < 123; i++)
      check($sformatf("long_byte%0d", i), 32'(tx_mem[TX + i]), 32'(pat(5 + i)));
    check("long_cr", 32'(tx_mem[TX + 123]), 32'h0D);
    check("long_lf", 32'(tx_mem[TX + 124]), 32'h0A);

    // Second command during COPY is dropped with one overrun pulse.
    load_cmd("echo hi");
    ovr0 = ovr_cnt;
    mv0  = mv_cnt;
    run_seq(7, 9, 1, -1, 30, we_a, busy_a, mv_a);
    check("ovr_copy_overrun", ovr_cnt - ovr0, 1);
    check("ovr_copy_msgs", mv_cnt - mv0, 1);
    check("ovr_copy_len", 32'(msg_len), 4);
    check("ovr_copy_b0", 32'(tx_mem[TX]), 32'h68);
    check("ovr_copy_b1", 32'(tx_mem[TX + 1]), 32'h69);
    check("ovr_copy_cr", 32'(tx_mem[TX + 2]), 32'h0D);

    // cmd_valid in the DONE cycle is also an overrun.
    load_cmd("xyz");
    ovr0 = ovr_cnt;
    mv0  = mv_cnt;
    run_seq(3, 10, 1, -1, 30, we_a, busy_a, mv_a);
    check("ovr_done_overrun", ovr_cnt - ovr0, 1);
    check("ovr_done_msgs", mv_cnt - mv0, 1);
    check("ovr_done_len", 32'(msg_len), 3);
    check("ovr_done_busy_end", 32'(busy), 0);

    // cmd_valid held high is one command and no overrun.
    load_cmd("up");
    ovr0 = ovr_cnt;
    mv0  = mv_cnt;
    run_seq(2, -1, 20, -1, 30, we_a, busy_a, mv_a);
    check("held_msgs", mv_cnt - mv0, 1);
    check("held_overrun", ovr_cnt - ovr0, 0);
    check("held_len", 32'(msg_len), 2);

    // Reset in the middle of COPY aborts without msg_valid.
    load_cmd("echo hi");
    mv0 = mv_cnt;
    run_seq(7, -1, 1, 9, 30, we_a, busy_a, mv_a);
    check("rstmid_mem_we", 32'(we_a), 0);
    check("rstmid_busy", 32'(busy_a), 0);
    check("rstmid_msg_valid", 32'(mv_a), 0);
    check("rstmid_msgs", mv_cnt - mv0, 0);
    run_cmd("after_rst", "echo ok", "ok", 4, 14);

    // msg_len holds after the pulse.
    repeat (3) @(negedge clk);
    check("msg_len_hold", 32'(msg_len), 4);
    check("no_write_below_tx", bad_wr, 0);
    check("max_write_addr", max_wr, TX + 124);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
